// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 sequential multiplier.
//   mult_state_t : controller states (IDLE, RUN, DONE), 2-bit encoding
//   iters()      : number of RUN cycles for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Two multiplier bits retire per cycle; odd widths round up.
    function automatic int unsigned iters(input int unsigned width);
        return (width + 1) / 2;
    endfunction

endpackage

// File: rtl/radix4_pp_row.sv
// Combinational radix-4 partial-product row: pp = m * qd.
// Ports:
//   m  [WIDTH-1:0] multiplicand
//   qd [1:0]       multiplier digit (0..3)
//   pp [WIDTH+1:0] partial product (0, m, 2m or 3m)
module radix4_pp_row #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] m,
    input  logic [1:0]       qd,
    output logic [WIDTH+1:0] pp
);

    logic [WIDTH+1:0] m1;
    logic [WIDTH+1:0] m2;

    always_comb begin
        m1 = (WIDTH+2)'(m);
        m2 = m1 << 1;
        case (qd)
            2'd0:    pp = '0;
            2'd1:    pp = m1;
            2'd2:    pp = m2;
            default: pp = m1 + m2;
        endcase
    end

endmodule

// File: rtl/radix4_seq_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier retiring two multiplier bits per clock.
// Valid/ready handshake on both the operand and the product side.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   m, q                multiplicand, multiplier
//   acc_in              accumulate addend, present only with MULT_ACC_EN
//   out_valid/out_ready product handshake
//   product             registered 2*WIDTH-bit result, stable while out_valid
//   busy                high while iterating
// Build option: define MULT_ACC_EN to add acc_in; product becomes (m*q + acc_in) mod 2^(2*WIDTH).
module radix4_seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
`ifdef MULT_ACC_EN
    input  logic [2*WIDTH-1:0]   acc_in,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned ITERS = iters(WIDTH);
    localparam int unsigned QW    = 2 * ITERS;
    localparam int unsigned PW    = 2 * WIDTH;
    // Wide enough to hold ITERS so the final increment cannot wrap.
    localparam int unsigned CW    = $clog2(ITERS + 1);

    mult_state_t      state;
    logic [WIDTH-1:0] m_reg;
    logic [QW-1:0]    q_reg;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] pp;
    logic [PW-1:0]    pp_shift;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    acc_init;

    radix4_pp_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .m  (m_reg),
        .qd (q_reg[1:0]),
        .pp (pp)
    );

    // The last shift may push zero bits past 2*WIDTH; truncation loses nothing.
    always_comb begin
        pp_shift = PW'(pp) << {cnt, 1'b0};
        acc_next = acc + pp_shift;
    end

`ifdef MULT_ACC_EN
    assign acc_init = acc_in;
`else
    assign acc_init = '0;
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg <= m;
                        q_reg <= QW'(q);
                        acc   <= acc_init;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_reg >> 2;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1)) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
